grid_lsq_arbiter: RTL and testbench
===================================

# grid_lsq_arbiter

Shared load/store arbiter between the reconfigurable grid's PR slots and the single core-side LSQ port. Each slot's LSQ interface (addr/data/fn3/load/store/new_request out, lsq_full/load_data/load_complete in) terminates here. The block buffers one pending request per slot and issues one request per cycle to the LSQ. A tag FIFO records which slot owns each outstanding load so that load responses are routed back in order.

## Interface
Parameters:
- NUM_SLOTS, 4, number of PR slots served (≥2)
- XLEN, 32, data/address width
- LOAD_TAG_DEPTH, 8, max outstanding loads (power of two)

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- slot_addr  in  NUM_SLOTS×XLEN  per-slot request address
- slot_data  in  NUM_SLOTS×XLEN  per-slot store data
- slot_fn3  in  NUM_SLOTS×3  per-slot access size/sign
- slot_load, slot_store  in  NUM_SLOTS  per-slot request type
- slot_new_request  in  NUM_SLOTS  per-slot one-cycle request pulse
- slot_lsq_full  out  NUM_SLOTS  per-slot back-pressure
- slot_load_data  out  XLEN  load data, broadcast to all slots
- slot_load_complete  out  NUM_SLOTS  one-hot load-response strobe
- lsq_addr, lsq_data  out  XLEN  issued request fields
- lsq_fn3  out  3  issued fn3
- lsq_load, lsq_store  out  1  issued type
- lsq_new_request  out  1  issue strobe
- lsq_full  in  1  LSQ back-pressure
- lsq_load_data  in  XLEN  returning load data
- lsq_load_complete  in  1  load response strobe (in issue order)
- tag_underflow  out  1  sticky: response with no outstanding load

## Operation
- Per slot: one holding register (valid, addr, data, fn3, load, store). slot_lsq_full[i] = hold_valid[i]. The register is captured when slot_new_request[i] is high and hold_valid[i] is low. A request while hold_valid[i] is high is dropped; the bench flags it as a protocol error.
- Eligibility: hold_valid[i] is set, lsq_full is low, and either the entry is a store or the tag FIFO is not full.
- Grant: at most one per cycle, round-robin. The pointer moves to the slot after the last grant. Search starts at the pointer. Pointer resets to 0.
- On grant: output register loads the fields and lsq_new_request is set for exactly one cycle. hold_valid[i] clears. For a load, slot index i is pushed into the tag FIFO.
- Response: when lsq_load_complete is high and the FIFO is non-empty, pop the head id. Register slot_load_data ← lsq_load_data and slot_load_complete ← one-hot(id).
- If the FIFO is empty on a response, no strobe is generated and tag_underflow sets. It clears only on reset.
- Push and pop of the tag FIFO in the same cycle are both honoured, including when the FIFO is full or empty-with-push.
- Stores produce no response.
- Reset values, asynchronous: all hold_valid=0, slot_lsq_full=0, lsq_new_request=0, lsq_load/lsq_store=0, lsq_addr/lsq_data/lsq_fn3=0, slot_load_complete=0, slot_load_data=0, FIFO empty, pointer 0, tag_underflow=0. Reset mid-operation discards all pending and outstanding state.

## Timing
- Request pulse at cycle t: hold_valid and slot_lsq_full are high from t+1.
- Earliest grant decision is at t+1. lsq_new_request and fields are valid at t+2, and slot_lsq_full drops at t+2.
- Minimum slot-to-LSQ latency is 2 cycles. Next accept from the same slot is at t+2, so its throughput is 1 request per 2 cycles. Aggregate throughput is 1 per cycle.
- lsq_full is sampled in the grant cycle. If high, no issue happens the next cycle.
- lsq_load_complete at cycle t gives slot_load_complete/slot_load_data at t+1, high for one cycle.
- LOAD_TAG_DEPTH outstanding loads blocks further load grants until a pop. A pop at t permits a load grant at t.

## Configuration
- GRID_LSQ_FIXED_PRIORITY_EN defined: grant is fixed-priority, lowest slot index wins, and the pointer logic is removed.
- Not defined: round-robin as above.
- All other behaviour is identical in both builds.

## Test plan
- Single load: slot 2 pulses a load at addr 0x100, fn3=2 → lsq_new_request at +2 with lsq_addr=0x100 and lsq_load=1. LSQ returns 0xDEADBEEF → slot_load_complete=4'b0100 and data 0xDEADBEEF one cycle later.
- Contention: all 4 slots pulse in the same cycle → issue order 0,1,2,3 on consecutive cycles (round-robin). Repeat → order continues from 0. Fixed-priority build: slot 0 refills each time and repeatedly wins while slot 3 waits.
- Back-pressure: lsq_full held high for 5 cycles with 3 slots pending → no lsq_new_request. slot_lsq_full stays high. Issues resume the cycle after lsq_full falls.
- Tag FIFO full: 8 loads outstanding, then one slot pending a load and another a store → only the store issues. One response → the load issues next.
- Ordering: loads from slots 3,1,3 are outstanding, then 3 responses → strobes 1000, 0010, 1000 with matching data.
- Underflow and reset: lsq_load_complete with nothing outstanding → no strobe, tag_underflow=1. Asserting rst_n low with requests pending clears every output within the same cycle.

Source files
------------

// File: rtl/grid_lsq_arbiter.sv
// Shared load/store arbiter: buffers one request per PR slot, issues one per cycle to the LSQ,
// and routes in-order load responses back via a tag FIFO. GRID_LSQ_FIXED_PRIORITY_EN selects fixed priority.
module grid_lsq_arbiter #(
    parameter int NUM_SLOTS      = 4,
    parameter int XLEN           = 32,
    parameter int LOAD_TAG_DEPTH = 8
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NUM_SLOTS*XLEN-1:0] slot_addr,
    input  logic [NUM_SLOTS*XLEN-1:0] slot_data,
    input  logic [NUM_SLOTS*3-1:0]    slot_fn3,
    input  logic [NUM_SLOTS-1:0]      slot_load,
    input  logic [NUM_SLOTS-1:0]      slot_store,
    input  logic [NUM_SLOTS-1:0]      slot_new_request,
    output logic [NUM_SLOTS-1:0]      slot_lsq_full,
    output logic [XLEN-1:0]           slot_load_data,
    output logic [NUM_SLOTS-1:0]      slot_load_complete,
    output logic [XLEN-1:0]           lsq_addr,
    output logic [XLEN-1:0]           lsq_data,
    output logic [2:0]                lsq_fn3,
    output logic                      lsq_load,
    output logic                      lsq_store,
    output logic                      lsq_new_request,
    input  logic                      lsq_full,
    input  logic [XLEN-1:0]           lsq_load_data,
    input  logic                      lsq_load_complete,
    output logic                      tag_underflow
);

    localparam int ID_W  = $clog2(NUM_SLOTS);
    localparam int PTR_W = $clog2(LOAD_TAG_DEPTH);
    localparam int CNT_W = $clog2(LOAD_TAG_DEPTH + 1);

    logic [NUM_SLOTS-1:0] hold_valid;
    logic [NUM_SLOTS-1:0] hold_load;
    logic [NUM_SLOTS-1:0] hold_store;
    logic [XLEN-1:0]      hold_addr [NUM_SLOTS];
    logic [XLEN-1:0]      hold_data [NUM_SLOTS];
    logic [2:0]           hold_fn3  [NUM_SLOTS];

    logic [NUM_SLOTS-1:0] capture;
    logic [NUM_SLOTS-1:0] eligible;
    logic                 grant_valid;
    logic [ID_W-1:0]      grant_idx;
    logic [NUM_SLOTS-1:0] grant_onehot;

    logic [ID_W-1:0]      tag_mem [LOAD_TAG_DEPTH];
    logic [PTR_W-1:0]     tag_wr_ptr;
    logic [PTR_W-1:0]     tag_rd_ptr;
    logic [CNT_W-1:0]     tag_count;
    logic                 tag_push;
    logic                 tag_pop;
    logic                 tag_room;
    logic [NUM_SLOTS-1:0] head_onehot;

    assign slot_lsq_full = hold_valid;
    assign capture       = slot_new_request & ~hold_valid;

    // A response in the same cycle frees a tag, so a load may be granted into a full FIFO.
    assign tag_pop  = lsq_load_complete && (tag_count != '0);
    assign tag_room = (tag_count != CNT_W'(LOAD_TAG_DEPTH)) || tag_pop;
    assign tag_push = grant_valid && hold_load[grant_idx];

    always_comb begin
        // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
        eligible = '0;
        for (int i = 0; i < NUM_SLOTS; i++) begin
            eligible[i] = hold_valid[i] && !lsq_full && (!hold_load[i] || tag_room);
        end
    end

`ifdef GRID_LSQ_FIXED_PRIORITY_EN
    always_comb begin
        grant_valid  = 1'b0;
        grant_idx    = '0;
        grant_onehot = '0;
        for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
            if (eligible[i]) begin
                grant_valid = 1'b1;
                grant_idx   = ID_W'(i);
            end
        end
        if (grant_valid) grant_onehot[grant_idx] = 1'b1;
    end
`else
    logic [ID_W-1:0] rr_ptr;

    function automatic logic [ID_W-1:0] rr_slot(input logic [ID_W-1:0] base, input int off);
        int s;
        s = int'(base) + off;
        if (s >= NUM_SLOTS) s -= NUM_SLOTS;
        return ID_W'(s);
    endfunction

    always_comb begin
        grant_valid  = 1'b0;
        grant_idx    = '0;
        grant_onehot = '0;
        for (int off = 0; off < NUM_SLOTS; off++) begin
            if (!grant_valid && eligible[rr_slot(rr_ptr, off)]) begin
                grant_valid = 1'b1;
                grant_idx   = rr_slot(rr_ptr, off);
            end
        end
        if (grant_valid) grant_onehot[grant_idx] = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr <= '0;
        end else if (grant_valid) begin
            rr_ptr <= (grant_idx == ID_W'(NUM_SLOTS - 1)) ? '0 : grant_idx + ID_W'(1);
        end
    end
`endif

    always_comb begin
        head_onehot = '0;
        head_onehot[tag_mem[tag_rd_ptr]] = 1'b1;
    end

    // NOTE: payload and tag storage are left unreset; valid bits and the tag count guard every read.
    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_SLOTS; i++) begin
            if (capture[i]) begin
                hold_addr[i]  <= slot_addr[i*XLEN +: XLEN];
                hold_data[i]  <= slot_data[i*XLEN +: XLEN];
                hold_fn3[i]   <= slot_fn3[i*3 +: 3];
                hold_load[i]  <= slot_load[i];
                hold_store[i] <= slot_store[i];
            end
        end
        if (tag_push) tag_mem[tag_wr_ptr] <= grant_idx;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
        if (!rst_n) begin
            hold_valid <= '0;
            tag_wr_ptr <= '0;
            tag_rd_ptr <= '0;
            tag_count  <= '0;
        end else begin
            hold_valid <= (hold_valid & ~grant_onehot) | capture;
            if (tag_push) tag_wr_ptr <= tag_wr_ptr + PTR_W'(1);
            if (tag_pop)  tag_rd_ptr <= tag_rd_ptr + PTR_W'(1);
            case ({tag_push, tag_pop})
                2'b10:   tag_count <= tag_count + CNT_W'(1);
                2'b01:   tag_count <= tag_count - CNT_W'(1);
                default: tag_count <= tag_count;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lsq_new_request    <= 1'b0;
            lsq_addr           <= '0;
            lsq_data           <= '0;
            lsq_fn3            <= '0;
            lsq_load           <= 1'b0;
            lsq_store          <= 1'b0;
            slot_load_complete <= '0;
            slot_load_data     <= '0;
            tag_underflow      <= 1'b0;
        end else begin
            lsq_new_request <= grant_valid;
            if (grant_valid) begin
                lsq_addr  <= hold_addr[grant_idx];
                lsq_data  <= hold_data[grant_idx];
                lsq_fn3   <= hold_fn3[grant_idx];
                lsq_load  <= hold_load[grant_idx];
                lsq_store <= hold_store[grant_idx];
            end
            slot_load_complete <= tag_pop ? head_onehot : '0;
            if (tag_pop) slot_load_data <= lsq_load_data;
            if (lsq_load_complete && (tag_count == '0)) tag_underflow <= 1'b1;
        end
    end

endmodule

// File: tb/tb_grid_lsq_arbiter.sv
// Testbench for grid_lsq_arbiter: directed scenarios plus randomized traffic checked against
// a queue-based reference model of pending requests, issue order and outstanding load tags.
module tb_grid_lsq_arbiter;

    localparam int N     = 4;
    localparam int XLEN  = 32;
    localparam int DEPTH = 8;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [N*XLEN-1:0] slot_addr = '0;
    logic [N*XLEN-1:0] slot_data = '0;
    logic [N*3-1:0]    slot_fn3 = '0;
    logic [N-1:0]      slot_load = '0;
    logic [N-1:0]      slot_store = '0;
    logic [N-1:0]      slot_new_request = '0;
    logic [N-1:0]      slot_lsq_full;
    logic [XLEN-1:0]   slot_load_data;
    logic [N-1:0]      slot_load_complete;
    logic [XLEN-1:0]   lsq_addr;
    logic [XLEN-1:0]   lsq_data;
    logic [2:0]        lsq_fn3;
    logic              lsq_load;
    logic              lsq_store;
    logic              lsq_new_request;
    logic              lsq_full = 1'b0;
    logic [XLEN-1:0]   lsq_load_data = '0;
    logic              lsq_load_complete = 1'b0;
    logic              tag_underflow;

    grid_lsq_arbiter #(.NUM_SLOTS(N), .XLEN(XLEN), .LOAD_TAG_DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n),
        .slot_addr(slot_addr), .slot_data(slot_data), .slot_fn3(slot_fn3),
        .slot_load(slot_load), .slot_store(slot_store), .slot_new_request(slot_new_request),
        .slot_lsq_full(slot_lsq_full), .slot_load_data(slot_load_data),
        .slot_load_complete(slot_load_complete),
        .lsq_addr(lsq_addr), .lsq_data(lsq_data), .lsq_fn3(lsq_fn3),
        .lsq_load(lsq_load), .lsq_store(lsq_store), .lsq_new_request(lsq_new_request),
        .lsq_full(lsq_full), .lsq_load_data(lsq_load_data),
        .lsq_load_complete(lsq_load_complete), .tag_underflow(tag_underflow)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [XLEN-1:0] addr;
        logic [XLEN-1:0] data;
        logic [2:0]      fn3;
        bit              ld;
    } req_t;

    int total = 0;
    int bad   = 0;

    // Reference model state
    req_t            pend [N];
    bit              pend_v [N];
    int              tagq [$];
    int              rr;
    bit              uf;
    bit              e_new;
    req_t            e_req;
    logic [N-1:0]    e_cmp;
    logic [XLEN-1:0] e_ldata;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < N; i++) pend_v[i] = 1'b0;
        tagq.delete();
        rr    = 0;
        uf    = 1'b0;
        e_new = 1'b0;
        e_cmp = '0;
    endtask

    // One clock edge of the arbitration rules, applied to the inputs present at that edge.
    task automatic model_step();
        bit old_v [N];
        bit pop, room;
        int g, s, id;
        old_v = pend_v;
        g     = -1;
        pop   = lsq_load_complete && (tagq.size() > 0);
        if (lsq_load_complete && tagq.size() == 0) uf = 1'b1;
        room = (tagq.size() < DEPTH) || pop;
        if (!lsq_full) begin
            for (int off = 0; off < N; off++) begin
`ifdef GRID_LSQ_FIXED_PRIORITY_EN
                s = off;
`else
                s = (rr + off) % N;
`endif
                if (g < 0 && pend_v[s] && (!pend[s].ld || room)) g = s;
            end
        end
        e_new = (g >= 0);
        e_cmp = '0;
        if (pop) begin
            id        = tagq.pop_front();
            e_cmp[id] = 1'b1;
            e_ldata   = lsq_load_data;
        end
        if (g >= 0) begin
            e_req     = pend[g];
            pend_v[g] = 1'b0;
            if (pend[g].ld) tagq.push_back(g);
            rr = (g + 1) % N;
        end
        for (int i = 0; i < N; i++) begin
            if (slot_new_request[i] && !old_v[i]) begin
                pend_v[i]    = 1'b1;
                pend[i].addr = slot_addr[i*XLEN +: XLEN];
                pend[i].data = slot_data[i*XLEN +: XLEN];
                pend[i].fn3  = slot_fn3[i*3 +: 3];
                pend[i].ld   = slot_load[i];
            end
        end
    endtask

    task automatic compare();
        logic [N-1:0] fullv;
        for (int i = 0; i < N; i++) fullv[i] = pend_v[i];
        check("slot_lsq_full", slot_lsq_full, fullv);
        check("lsq_new_request", lsq_new_request, e_new);
        if (e_new) begin
            check("lsq_addr", lsq_addr, e_req.addr);
            check("lsq_data", lsq_data, e_req.data);
            check("lsq_fn3", lsq_fn3, e_req.fn3);
            check("lsq_load", lsq_load, e_req.ld);
            check("lsq_store", lsq_store, !e_req.ld);
        end
        check("slot_load_complete", slot_load_complete, e_cmp);
        if (e_cmp != '0) check("slot_load_data", slot_load_data, e_ldata);
        check("tag_underflow", tag_underflow, uf);
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        compare();
        slot_new_request  = '0;
        lsq_load_complete = 1'b0;
    endtask

    task automatic post(input int s, input bit ld, input logic [XLEN-1:0] a,
                        input logic [XLEN-1:0] d, input logic [2:0] f);
        slot_addr[s*XLEN +: XLEN] = a;
        slot_data[s*XLEN +: XLEN] = d;
        slot_fn3[s*3 +: 3]        = f;
        slot_load[s]              = ld;
        slot_store[s]             = !ld;
        slot_new_request[s]       = 1'b1;
    endtask

    task automatic wait_free(input int s);
        for (int k = 0; k < 50 && pend_v[s]; k++) tick();
        check("wait_free", slot_lsq_full[s], 1'b0);
    endtask

    task automatic drain();
        lsq_full = 1'b0;
        for (int k = 0; k < 200; k++) begin
            if (tagq.size() == 0 && !(pend_v[0] || pend_v[1] || pend_v[2] || pend_v[3])) break;
            lsq_load_data     = $urandom;
            lsq_load_complete = (tagq.size() > 0);
            tick();
        end
        check("drain_full", slot_lsq_full, '0);
        check("drain_tags", tagq.size(), 0);
    endtask

    task automatic check_reset_outputs();
        check("rst_slot_lsq_full", slot_lsq_full, '0);
        check("rst_new_request", lsq_new_request, 1'b0);
        check("rst_lsq_load", lsq_load, 1'b0);
        check("rst_lsq_store", lsq_store, 1'b0);
        check("rst_lsq_addr", lsq_addr, '0);
        check("rst_lsq_data", lsq_data, '0);
        check("rst_lsq_fn3", lsq_fn3, '0);
        check("rst_load_complete", slot_load_complete, '0);
        check("rst_load_data", slot_load_data, '0);
        check("rst_underflow", tag_underflow, 1'b0);
    endtask

    task automatic do_reset();
        rst_n            = 1'b0;
        slot_new_request = '0;
        lsq_full         = 1'b0;
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [XLEN-1:0] od [3];
        logic [N-1:0]    os [3];

        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs();
        @(negedge clk);
        rst_n = 1'b1;

        // Single load from slot 2
        post(2, 1'b1, 32'h100, 32'h0, 3'd2);
        tick();
        check("single_pending", slot_lsq_full, 4'b0100);
        tick();
        check("single_issue", lsq_new_request, 1'b1);
        check("single_addr", lsq_addr, 32'h100);
        check("single_is_load", lsq_load, 1'b1);
        check("single_fn3", lsq_fn3, 3'd2);
        check("single_released", slot_lsq_full, 4'b0000);
        lsq_load_data     = 32'hDEADBEEF;
        lsq_load_complete = 1'b1;
        tick();
        check("single_strobe", slot_load_complete, 4'b0100);
        check("single_data", slot_load_data, 32'hDEADBEEF);
        tick();
        check("single_strobe_one_cycle", slot_load_complete, 4'b0000);

        // Contention: all slots at once, twice, from a fresh pointer
        do_reset();
        for (int round = 0; round < 2; round++) begin
            for (int s = 0; s < N; s++) post(s, 1'b0, 32'h200 + 16 * round + s, 32'(s), 3'd0);
            tick();
            for (int k = 0; k < N; k++) begin
                tick();
                check("contention_issue", lsq_new_request, 1'b1);
                check("contention_order", lsq_addr, 32'h200 + 16 * round + k);
            end
        end

        // Back-pressure with three slots pending
        lsq_full = 1'b1;
        for (int s = 0; s < 3; s++) post(s, 1'b0, 32'h280 + s, 32'h0, 3'd1);
        tick();
        for (int k = 0; k < 5; k++) begin
            tick();
            check("bp_no_issue", lsq_new_request, 1'b0);
            check("bp_held", slot_lsq_full, 4'b0111);
        end
        lsq_full = 1'b0;
        tick();
        check("bp_resume", lsq_new_request, 1'b1);
        drain();

        // Tag FIFO full: store passes, load waits for a response
        for (int n = 0; n < DEPTH; n++) begin
            wait_free(n % N);
            post(n % N, 1'b1, 32'h300 + n, 32'h0, 3'd2);
            tick();
        end
        for (int k = 0; k < 10 && tagq.size() < DEPTH; k++) tick();
        check("fifo_filled", tagq.size(), DEPTH);
        check("fifo_filled_idle", slot_lsq_full, 4'b0000);
        post(0, 1'b1, 32'h400, 32'h0, 3'd2);
        post(1, 1'b0, 32'h500, 32'h55, 3'd2);
        tick();
        tick();
        check("fifo_store_issue", lsq_new_request, 1'b1);
        check("fifo_store_kind", lsq_store, 1'b1);
        check("fifo_store_addr", lsq_addr, 32'h500);
        tick();
        check("fifo_load_blocked", lsq_new_request, 1'b0);
        check("fifo_load_waiting", slot_lsq_full, 4'b0001);
        lsq_load_data     = 32'h1234;
        lsq_load_complete = 1'b1;
        tick();
        check("fifo_load_issue", lsq_new_request, 1'b1);
        check("fifo_load_addr", lsq_addr, 32'h400);
        drain();

        // Response ordering for loads from slots 3,1,3
        post(3, 1'b1, 32'h600, 32'h0, 3'd0);
        tick();
        post(1, 1'b1, 32'h610, 32'h0, 3'd0);
        tick();
        wait_free(3);
        post(3, 1'b1, 32'h620, 32'h0, 3'd0);
        tick();
        for (int k = 0; k < 10 && tagq.size() < 3; k++) tick();
        od[0] = 32'hA0A0_0001; os[0] = 4'b1000;
        od[1] = 32'hB0B0_0002; os[1] = 4'b0010;
        od[2] = 32'hC0C0_0003; os[2] = 4'b1000;
        for (int k = 0; k < 3; k++) begin
            lsq_load_data     = od[k];
            lsq_load_complete = 1'b1;
            tick();
            check("order_strobe", slot_load_complete, os[k]);
            check("order_data", slot_load_data, od[k]);
        end

        // Randomized traffic
        for (int cyc = 0; cyc < 1500; cyc++) begin
            for (int s = 0; s < N; s++) begin
                if (!pend_v[s] && $urandom_range(0, 99) < 40)
                    post(s, 1'($urandom_range(0, 1)), $urandom, $urandom, 3'($urandom_range(0, 7)));
            end
            lsq_full          = ($urandom_range(0, 99) < 20);
            lsq_load_data     = $urandom;
            lsq_load_complete = (tagq.size() > 0) && ($urandom_range(0, 99) < 35);
            tick();
        end
        drain();

        // Underflow
        lsq_load_complete = 1'b1;
        tick();
        check("uf_no_strobe", slot_load_complete, 4'b0000);
        check("uf_flag", tag_underflow, 1'b1);
        tick();
        check("uf_sticky", tag_underflow, 1'b1);

        // Asynchronous reset with requests pending and an issue in flight
        post(0, 1'b1, 32'h700, 32'h0, 3'd2);
        post(2, 1'b0, 32'h710, 32'h7, 3'd2);
        tick();
        tick();
        check("pre_reset_issue", lsq_new_request, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_outputs();
        do_reset();
        for (int k = 0; k < 3; k++) tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
